// File: rtl/sum_accumulator_if.sv
// Handshake bundle for sum_accumulator: sample stream in, frame totals out.
// master is the surrounding logic; slave is the accumulator itself.
interface sum_accumulator_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
);
    logic                 clear;
    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_overflow;
    logic                 out_ready;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_overflow
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_overflow
    );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned samples into a saturating ACC_WIDTH-bit frame total
// and holds each total in a registered valid/ready output with a sticky overflow flag.
module sum_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 4
) (
    input  logic              clk,
    input  logic              rst,
    sum_accumulator_if.slave  bus
);
    localparam int CW = $clog2(COUNT);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_overflow_q, out_overflow_d;

    logic [ACC_WIDTH:0]   sum;
    logic                 beat_ovf;
    logic [ACC_WIDTH-1:0] result;
    logic                 final_beat;
    logic                 in_ready;
    logic                 accept;

    always_comb begin
        sum      = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, bus.in_data};
        beat_ovf = sum[ACC_WIDTH];
        result   = beat_ovf ? '1 : sum[ACC_WIDTH-1:0];
        final_beat = (cnt_q == LAST);
        // Only the closing beat needs a free output slot; earlier beats never stall.
        in_ready = !bus.clear && !(final_beat && out_valid_q && !bus.out_ready);
        accept   = bus.in_valid && in_ready;
    end

    always_comb begin
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_overflow_d = out_overflow_q;

        if (out_valid_q && bus.out_ready)
            out_valid_d = 1'b0;

        if (bus.clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            if (final_beat) begin
                out_data_d     = result;
                out_overflow_d = ovf_q | beat_ovf;
                out_valid_d    = 1'b1;
                acc_d          = '0;
                cnt_d          = '0;
                ovf_d          = 1'b0;
            end else begin
                acc_d = result;
                cnt_d = cnt_q + CW'(1);
                ovf_d = ovf_q | beat_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q          <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_overflow = out_overflow_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a 16-bit instance for the main scenarios
// and a 9-bit instance for saturation.
module tb_sum_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    sum_accumulator_if #(.WIDTH(8), .ACC_WIDTH(16)) bus ();
    sum_accumulator_if #(.WIDTH(8), .ACC_WIDTH(9))  sbus ();

    sum_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sum_accumulator #(.WIDTH(8), .ACC_WIDTH(9), .COUNT(4)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic sbeat(input logic [7:0] d);
        sbus.in_valid = 1'b1;
        sbus.in_data  = d;
        step();
        sbus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); else passes++;
        checks++; if (bus.out_data !== 16'd0) $display("FAIL reset_out_data got %0d want 0", bus.out_data); else passes++;
        checks++; if (bus.out_overflow !== 1'b0) $display("FAIL reset_out_overflow got %0b want 0", bus.out_overflow); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); else passes++;
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        beat(8'd10);
        beat(8'd20);
        beat(8'd30);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid got %0b want 0", bus.out_valid); else passes++;
        beat(8'd40);
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got %0b want 1", bus.out_valid); else passes++;
        checks++; if (bus.out_data !== 16'd100) $display("FAIL basic_data got %0d want 100", bus.out_data); else passes++;
        checks++; if (bus.out_overflow !== 1'b0) $display("FAIL basic_ovf got %0b want 0", bus.out_overflow); else passes++;
        step();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_drop got %0b want 0", bus.out_valid); else passes++;
    endtask

    task automatic test_saturation();
        sbus.out_ready = 1'b1;
        repeat (4) sbeat(8'd255);
        checks++; if (sbus.out_valid !== 1'b1) $display("FAIL sat_valid got %0b want 1", sbus.out_valid); else passes++;
        checks++; if (sbus.out_data !== 9'd511) $display("FAIL sat_data got %0d want 511", sbus.out_data); else passes++;
        checks++; if (sbus.out_overflow !== 1'b1) $display("FAIL sat_ovf got %0b want 1", sbus.out_overflow); else passes++;
        repeat (4) sbeat(8'd1);
        checks++; if (sbus.out_data !== 9'd4) $display("FAIL sat_next_data got %0d want 4", sbus.out_data); else passes++;
        checks++; if (sbus.out_overflow !== 1'b0) $display("FAIL sat_next_ovf got %0b want 0", sbus.out_overflow); else passes++;
        step();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        beat(8'd1); beat(8'd2); beat(8'd3); beat(8'd4);
        checks++; if (bus.out_data !== 16'd10 || bus.out_valid !== 1'b1)
            $display("FAIL bp_first got data %0d valid %0b want 10/1", bus.out_data, bus.out_valid); else passes++;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'd5;
            #1;
            checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_beat%0d got %0b want 1", i, bus.in_ready); else passes++;
            step();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd5;
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_stall got %0b want 0", bus.in_ready); else passes++;
        step();
        checks++; if (bus.out_data !== 16'd10 || bus.out_valid !== 1'b1)
            $display("FAIL bp_hold got data %0d valid %0b want 10/1", bus.out_data, bus.out_valid); else passes++;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready got %0b want 1", bus.in_ready); else passes++;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_data !== 16'd20 || bus.out_valid !== 1'b1)
            $display("FAIL bp_swap got data %0d valid %0b want 20/1", bus.out_data, bus.out_valid); else passes++;
        step();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_pop got %0b want 0", bus.out_valid); else passes++;
    endtask

    task automatic test_clear();
        bus.out_ready = 1'b1;
        beat(8'd5);
        beat(8'd6);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd7;
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL clear_ready got %0b want 0", bus.in_ready); else passes++;
        step();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) beat(8'd1);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL clear_early_valid got %0b want 0", bus.out_valid); else passes++;
        beat(8'd1);
        checks++; if (bus.out_data !== 16'd4 || bus.out_valid !== 1'b1)
            $display("FAIL clear_data got data %0d valid %0b want 4/1", bus.out_data, bus.out_valid); else passes++;
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        repeat (4) beat(8'd1);
        beat(8'd2);
        beat(8'd3);
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL rstmid_pre_valid got %0b want 1", bus.out_valid); else passes++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_valid got %0b want 0", bus.out_valid); else passes++;
        checks++; if (bus.out_data !== 16'd0) $display("FAIL rstmid_data got %0d want 0", bus.out_data); else passes++;
        checks++; if (bus.out_overflow !== 1'b0) $display("FAIL rstmid_ovf got %0b want 0", bus.out_overflow); else passes++;
        bus.out_ready = 1'b1;
        beat(8'd1); beat(8'd2); beat(8'd3); beat(8'd4);
        checks++; if (bus.out_data !== 16'd10 || bus.out_valid !== 1'b1)
            $display("FAIL rstmid_frame got data %0d valid %0b want 10/1", bus.out_data, bus.out_valid); else passes++;
        step();
    endtask

    task automatic test_streaming();
        logic [15:0] exp_tot [3];
        exp_tot[0] = 16'd6; exp_tot[1] = 16'd22; exp_tot[2] = 16'd38;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_data = 8'(i);
            step();
            checks++;
            if (bus.out_valid !== ((i % 4) == 3))
                $display("FAIL stream_valid_c%0d got %0b want %0b", i, bus.out_valid, ((i % 4) == 3));
            else passes++;
            if ((i % 4) == 3) begin
                checks++;
                if (bus.out_data !== exp_tot[i / 4])
                    $display("FAIL stream_data_f%0d got %0d want %0d", i / 4, bus.out_data, exp_tot[i / 4]);
                else passes++;
            end
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    initial begin
        bus.clear = 1'b0;  bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b0;
        sbus.clear = 1'b0; sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_streaming();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
